// File: rtl/paula_audio_sigmadelta_decoder.sv
// Stereo 1-bit sigma/delta bitstream decoder built from a 3rd-order CIC
// decimator per channel, running at the clk7_en bit rate.
// Optional macro PAULA_SD_DECODER_DCBLOCK_EN adds a first-order DC blocker
// behind the CIC scaling; it costs one extra clk of output latency.
module paula_audio_sigmadelta_decoder #(
    parameter int DW   = 15,
    parameter int LOGR = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clk7_en,
    input  logic                 left,
    input  logic                 right,
    output logic signed [DW-1:0] ldata,
    output logic signed [DW-1:0] rdata,
    output logic                 sample_valid
);

    // Internal CIC width and the shift that brings the full-scale CIC gain
    // down to the output sample width.
    localparam int W  = 3 * LOGR + 2;
    localparam int SH = 3 * LOGR - (DW - 1);
    localparam logic signed [W-1:0] SAT_POS = W'((1 << (DW - 1)) - 1);

    // Channel 0 is left, channel 1 is right throughout.
    logic [1:0]         bitIn;
    logic [1:0][W-1:0]  xIn;
    logic [LOGR-1:0]    decCnt_q;
    logic               tick;

    logic [1:0][W-1:0]  integ1_q, integ2_q, integ3_q;
    logic [1:0][W-1:0]  dly1_q, dly2_q, dly3_q;
    logic [1:0][W-1:0]  comb1, comb2, comb3;
    logic [1:0][W-1:0]  shifted;
    logic [1:0][DW-1:0] scaled;

    logic [1:0][DW-1:0] outData_q;
    logic               valid_q;

    assign bitIn = {right, left};
    assign tick  = clk7_en && (decCnt_q == '1);

    // Map each input bit to +1 / -1 and build the comb differences and the
    // scaled, positively saturated CIC result.
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            xIn[ch]     = bitIn[ch] ? W'(1) : {W{1'b1}};
            comb1[ch]   = integ3_q[ch] - dly1_q[ch];
            comb2[ch]   = comb1[ch] - dly2_q[ch];
            comb3[ch]   = comb2[ch] - dly3_q[ch];
            shifted[ch] = W'(signed'(comb3[ch]) >>> SH);
            if (signed'(shifted[ch]) > SAT_POS) begin
                scaled[ch] = SAT_POS[DW-1:0];
            end else begin
                scaled[ch] = shifted[ch][DW-1:0];
            end
        end
    end

    // Integrator cascade; each stage adds the previous stage's registered
    // value, and wrap-around is intended (the combs undo it).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            integ1_q <= '0;
            integ2_q <= '0;
            integ3_q <= '0;
        end else if (clk7_en) begin
            for (int ch = 0; ch < 2; ch++) begin
                integ1_q[ch] <= integ1_q[ch] + xIn[ch];
                integ2_q[ch] <= integ2_q[ch] + integ1_q[ch];
                integ3_q[ch] <= integ3_q[ch] + integ2_q[ch];
            end
        end
    end

    // Shared decimation counter; the tick fires when it is about to wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            decCnt_q <= '0;
        end else if (clk7_en) begin
            decCnt_q <= decCnt_q + 1'b1;
        end
    end

    // Comb delay registers, advanced once per decimated sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dly1_q <= '0;
            dly2_q <= '0;
            dly3_q <= '0;
        end else if (tick) begin
            for (int ch = 0; ch < 2; ch++) begin
                dly1_q[ch] <= integ3_q[ch];
                dly2_q[ch] <= comb1[ch];
                dly3_q[ch] <= comb2[ch];
            end
        end
    end

`ifdef PAULA_SD_DECODER_DCBLOCK_EN
    localparam int AW = DW + 8;
    localparam logic signed [AW-1:0] OUT_MAX = AW'((1 << (DW - 1)) - 1);
    localparam logic signed [AW-1:0] OUT_MIN = AW'(-(1 << (DW - 1)));

    logic [1:0][DW-1:0] sHold_q, sPrev_q;
    logic [1:0][AW-1:0] yPrev_q;
    logic [1:0][AW-1:0] sExt, pExt, yNext;
    logic [1:0][DW-1:0] yOut;
    logic               pend_q;

    // Blocker arithmetic: y = s - s_prev + y_prev - (y_prev >>> 8),
    // followed by saturation back to the sample width.
    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            sExt[ch]  = {{8{sHold_q[ch][DW-1]}}, sHold_q[ch]};
            pExt[ch]  = {{8{sPrev_q[ch][DW-1]}}, sPrev_q[ch]};
            yNext[ch] = sExt[ch] - pExt[ch] + yPrev_q[ch]
                        - AW'(signed'(yPrev_q[ch]) >>> 8);
            if (signed'(yNext[ch]) > OUT_MAX) begin
                yOut[ch] = OUT_MAX[DW-1:0];
            end else if (signed'(yNext[ch]) < OUT_MIN) begin
                yOut[ch] = OUT_MIN[DW-1:0];
            end else begin
                yOut[ch] = yNext[ch][DW-1:0];
            end
        end
    end

    // Capture the scaled CIC sample on the tick, then run the blocker on the
    // following clk so the valid pulse lines up with the blocked output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sHold_q   <= '0;
            sPrev_q   <= '0;
            yPrev_q   <= '0;
            pend_q    <= 1'b0;
            outData_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            pend_q  <= tick;
            valid_q <= pend_q;
            if (tick) begin
                sHold_q <= scaled;
            end
            if (pend_q) begin
                sPrev_q   <= sHold_q;
                yPrev_q   <= yNext;
                outData_q <= yOut;
            end
        end
    end
`else
    // Register the scaled CIC sample on the tick and pulse valid for one clk.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outData_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= tick;
            if (tick) begin
                outData_q <= scaled;
            end
        end
    end
`endif

    assign ldata        = outData_q[0];
    assign rdata        = outData_q[1];
    assign sample_valid = valid_q;

endmodule
